// File: rtl/uart_tx_fifo_feed.sv
// Byte FIFO that feeds a downstream UART byte transmitter.
// Writes are accepted in any state. The feeder pops one byte and pulses send_go,
// waits for tx_done, then idles for GAP_CYCLES clocks before it pops the next byte.
module uart_tx_fifo_feed #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill_cnt,
  output logic                     overflow,
  output logic [7:0]               data_byte,
  output logic                     send_go,
  input  logic                     tx_done,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            push;
  logic            pop;

  // Full is checked before any same-cycle pop, so a write into a full FIFO is dropped.
  assign push     = wr_en && !full;
  assign pop      = (state == IDLE) && !empty;
  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  assign fill_cnt = cnt;

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Launch register: the popped byte and its start pulse appear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_go   <= 1'b0;
      data_byte <= 8'h00;
    end else begin
      send_go <= pop;
      if (pop) data_byte <= mem[rd_ptr];
    end
  end

  // State register and the gap counter that runs only while in GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  // Next-state logic; tx_done only matters while waiting for the transmitter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:       if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo_feed.sv
// Directed bench for uart_tx_fifo_feed: a scoreboard queue holds every accepted byte
// and is drained in order as send_go pulses appear; tx_done is returned by a
// programmable-delay responder inside the cycle step task.
module tb_uart_tx_fifo_feed;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] fill_cnt;
  logic       overflow;
  logic [7:0] data_byte;
  logic       send_go;
  logic       tx_done;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_go  = 0;
  int         n_ovf = 0;
  int         cyc   = 0;
  int         done_delay = -1;
  int         done_cd    = -1;
  int         last_done  = -1;
  logic [7:0] last_byte  = 8'h00;
  logic [7:0] q[$];

  uart_tx_fifo_feed #(.DEPTH(16), .GAP_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .fill_cnt  (fill_cnt),
    .overflow  (overflow),
    .data_byte (data_byte),
    .send_go   (send_go),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, score send_go, then drive tx_done for the next cycle.
  task automatic step();
    logic       rst_s;
    logic [7:0] exp_b;
    rst_s = rst;
    @(posedge clk);
    #1;
    cyc++;
    tx_done = 1'b0;
    if (overflow) n_ovf++;
    if (rst_s) begin
      last_byte = 8'h00;
      last_done = -1;
    end else if (send_go) begin
      n_go++;
      chk("go_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        chk("data_byte", 32'(data_byte), 32'(exp_b));
      end
      if (last_done >= 0) begin
        chk("gap_after_done", 32'((cyc - last_done) >= 3), 32'd1);
      end
      last_done = -1;
      last_byte = data_byte;
      done_cd   = done_delay;
    end else begin
      chk("data_hold", 32'(data_byte), 32'(last_byte));
    end
    if (done_cd == 0) begin
      tx_done   = 1'b1;
      done_cd   = -1;
      last_done = cyc;
    end else if (done_cd > 0) begin
      done_cd--;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_accept) q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  // Run until everything queued has been sent and the feeder is back in IDLE.
  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (!busy && empty && q.size() == 0 && done_cd < 0 && !tx_done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    int go0;
    int ovf0;
    int i;
    int guard;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_done = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_send_go", 32'(send_go), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_data_byte", 32'(data_byte), 32'h00);
    rst = 1'b0;
    step();

    // Single byte: write edge, pop edge, send_go right after the pop edge
    done_delay = 5;
    write_byte(8'hA5, 1'b1);
    chk("single_fill_after_wr", 32'(fill_cnt), 32'd1);
    chk("single_no_go_yet", 32'(send_go), 32'd0);
    chk("single_idle_at_wr", 32'(busy), 32'd0);
    step();
    chk("single_send_go", 32'(send_go), 32'd1);
    chk("single_data", 32'(data_byte), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_popped", 32'(fill_cnt), 32'd0);
    for (int k = 0; k < 50 && !tx_done; k++) step();
    chk("single_done_seen", 32'(tx_done), 32'd1);
    step();
    chk("single_gap1_busy", 32'(busy), 32'd1);
    step();
    chk("single_gap2_busy", 32'(busy), 32'd1);
    step();
    chk("single_back_idle", 32'(busy), 32'd0);
    chk("single_no_rego", 32'(send_go), 32'd0);

    // Burst of five with a slow transmitter
    done_delay = 20;
    go0 = n_go;
    for (int b = 1; b <= 5; b++) write_byte(8'(b), 1'b1);
    wait_idle(1000);
    chk("burst_go_count", 32'(n_go - go0), 32'd5);

    // Overflow with tx_done withheld
    done_delay = -1;
    go0  = n_go;
    ovf0 = n_ovf;
    for (int b = 0; b < 17; b++) write_byte(8'(8'h80 + b), 1'b1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_fill16", 32'(fill_cnt), 32'd16);
    chk("ovf_one_pop", 32'(n_go - go0), 32'd1);
    write_byte(8'hEE, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_fill_kept", 32'(fill_cnt), 32'd16);
    step();
    chk("ovf_pulse_one_cycle", 32'(overflow), 32'd0);
    chk("ovf_fill_still16", 32'(fill_cnt), 32'd16);
    // Drain with tx_done returned in the send_go cycle itself
    done_delay = 0;
    done_cd    = 0;
    wait_idle(2000);
    chk("ovf_total_go", 32'(n_go - go0), 32'd17);
    chk("ovf_single_event", 32'(n_ovf - ovf0), 32'd1);

    // Simultaneous write and IDLE pop with three bytes queued
    done_delay = -1;
    write_byte(8'hC0, 1'b1);
    write_byte(8'hC1, 1'b1);
    write_byte(8'hC2, 1'b1);
    write_byte(8'hC3, 1'b1);
    chk("simul_fill3", 32'(fill_cnt), 32'd3);
    done_cd = 0;
    for (int k = 0; k < 20 && busy; k++) step();
    chk("simul_reached_idle", 32'(busy), 32'd0);
    chk("simul_fill3_at_idle", 32'(fill_cnt), 32'd3);
    done_delay = 2;
    write_byte(8'hC4, 1'b1);
    chk("simul_fill_unchanged", 32'(fill_cnt), 32'd3);
    chk("simul_send_go", 32'(send_go), 32'd1);
    wait_idle(500);

    // Wrap-around: 40 incrementing bytes through 16 entries
    done_delay = 1;
    go0  = n_go;
    ovf0 = n_ovf;
    i     = 0;
    guard = 0;
    while (i < 40 && guard < 3000) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_data = 8'(8'h10 + i);
        q.push_back(wr_data);
        i++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      guard++;
    end
    wr_en = 1'b0;
    chk("wrap_all_written", 32'(i), 32'd40);
    wait_idle(3000);
    chk("wrap_go_count", 32'(n_go - go0), 32'd40);
    chk("wrap_no_overflow", 32'(n_ovf - ovf0), 32'd0);

    // Reset during WAIT_DONE with five bytes queued
    done_delay = -1;
    for (int b = 0; b < 6; b++) write_byte(8'(8'hD0 + b), 1'b1);
    chk("mid_fill5", 32'(fill_cnt), 32'd5);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_send_go", 32'(send_go), 32'd0);
    chk("mid_rst_fill", 32'(fill_cnt), 32'd0);
    go0 = n_go;
    done_cd = 0;
    for (int k = 0; k < 6; k++) step();
    chk("mid_stray_done_no_go", 32'(n_go - go0), 32'd0);
    chk("mid_stray_done_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_feed.md
UART_TX_FIFO_FEED -- requirements
Module: uart_tx_fifo_feed

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of 2, from 4 to 256).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle clk cycles inserted after each tx_done (0 allowed).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  write request for wr_data.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port fill_cnt  output  log2(DEPTH)+1  bytes currently stored.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 SHALL have port data_byte  output  8  byte presented to downstream byte transmitter.
REQ-012 SHALL have port send_go  output  1  one-cycle start pulse to downstream transmitter.
REQ-013 SHALL have port tx_done  input  1  one-cycle completion pulse from downstream transmitter.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL accept a write when wr_en=1 and full=0 in that cycle: mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH.
REQ-016 SHALL drop the write when wr_en=1 and full=1 (evaluated before any same-cycle pop), pulse overflow for exactly one cycle, and leave contents and pointers unchanged.
REQ-017 SHALL derive full, empty and fill_cnt from registered state so that they reflect the cycle after the write or pop edge.
REQ-018 SHALL leave fill_cnt unchanged on a simultaneous accepted write and pop.
REQ-019 SHALL implement a state machine with states IDLE, WAIT_DONE and GAP.
REQ-020 SHALL, in IDLE with empty=0, pop on that edge: data_byte <= mem[rd_ptr], rd_ptr increments modulo DEPTH, send_go <= 1, next state WAIT_DONE.
REQ-021 SHALL hold send_go high for exactly one cycle, with data_byte already valid in that same cycle.
REQ-022 SHALL hold data_byte stable from send_go until the next pop.
REQ-023 SHALL stay in WAIT_DONE until tx_done=1, then go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-024 SHALL count GAP_CYCLES cycles in GAP, then return to IDLE.
REQ-025 SHALL ignore tx_done in IDLE and GAP.
REQ-026 SHALL honour tx_done arriving in the first WAIT_DONE cycle (the send_go cycle).
REQ-027 SHALL assert the first send_go two cycles after the wr_en cycle when the FIFO is empty and the block is idle (write at edge N, pop at edge N+1, send_go high after edge N+1).
REQ-028 SHALL keep accepting writes in every state.
REQ-029 SHALL wrap rd_ptr and wr_ptr across DEPTH with no loss or duplication of bytes.

Reset
REQ-030 SHALL, when rst=1 at a clk edge, set state=IDLE, rd_ptr=wr_ptr=0, fill_cnt=0, empty=1, full=0, overflow=0, send_go=0, data_byte=8'h00, busy=0, and clear the gap counter.
REQ-031 SHALL, when reset is asserted mid-transfer, discard all queued bytes and ignore any later tx_done until a new send_go.
REQ-032 SHALL NOT require FIFO memory contents to be reset.

Verification
REQ-033 SHALL verify single byte: write 8'hA5 at cycle 0 while idle -> send_go=1 with data_byte=8'hA5 at cycle 2; busy=1 until tx_done + 2 gap cycles.
REQ-034 SHALL verify burst order: write 8'h01..8'h05 back-to-back, return tx_done 20 cycles after each send_go -> exactly five send_go pulses carrying 01..05 in order, with at least 2 idle cycles between tx_done and the next send_go.
REQ-035 SHALL verify overflow: with tx_done withheld, write 17 bytes (DEPTH=16) -> 1 byte popped; full=1 after 17 accepted writes total; the next write pulses overflow and fill_cnt stays 16.
REQ-036 SHALL verify simultaneous write and pop: FIFO holds 3 bytes, write in the same cycle as the IDLE pop -> fill_cnt stays 3 and the new byte is sent last.
REQ-037 SHALL verify wrap-around: push and drain 40 incrementing bytes through DEPTH=16 -> output sequence identical, no overflow.
REQ-038 SHALL verify reset mid-operation: assert rst during WAIT_DONE with 5 bytes queued -> next cycle empty=1, busy=0, send_go=0; a stray tx_done causes no send_go.
